// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
//   Drains the UART receive FIFO and assembles 5-byte host move packets
//   (SYNC, PIECE, POS, ORIENT, CHK) into one validated Blokus move command.
//   Checks the XOR checksum first, then the piece, coordinate and orientation
//   ranges. A validated command is held with cmd_valid until the consumer
//   takes it. No bytes are popped while a command is held, so the FIFO
//   buffers the host's next packet in the meantime.
//
// Ports
//   clk        system clock
//   reset_pin  asynchronous active-low reset
//   rx_empty   FIFO empty flag
//   r_data     FIFO head byte, valid while rx_empty=0
//   rd_rx_pin  active-low registered pop strobe, one cycle wide
//   cmd_valid  command available; held until cmd_ready
//   cmd_ready  consumer accepts command (ignored while cmd_valid=0)
//   cmd_piece  piece id
//   cmd_x      column
//   cmd_y      row
//   cmd_orient orientation/flip code
//   err_pulse  one-cycle error strobe
//   err_code   01 timeout, 10 checksum, 11 range; held until the next error
//   busy       high whenever the sequencer is not hunting for SYNC
//
// Optional build macro CMD_SEQ_STATS_EN adds these statistics outputs:
//   cmd_count[15:0] counts accepted commands and wraps.
//   err_count[7:0]  counts error pulses and saturates at 8'hFF.

module uart_cmd_sequencer #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 200000,
  parameter int         BOARD_MAX      = 13,
  parameter int         PIECE_MAX      = 20
) (
  input  logic       clk,
  input  logic       reset_pin,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_rx_pin,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [4:0] cmd_piece,
  output logic [3:0] cmd_x,
  output logic [3:0] cmd_y,
  output logic [2:0] cmd_orient,
  output logic       err_pulse,
  output logic [1:0] err_code,
  output logic       busy
`ifdef CMD_SEQ_STATS_EN
  ,
  output logic [15:0] cmd_count,
  output logic [7:0]  err_count
`endif
);

  localparam int            TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    PIECE_LIM  = 8'(PIECE_MAX);
  localparam logic [3:0]    BOARD_LIM  = 4'(BOARD_MAX);

  localparam logic [2:0] ST_HUNT     = 3'd0;
  localparam logic [2:0] ST_B_PIECE  = 3'd1;
  localparam logic [2:0] ST_B_POS    = 3'd2;
  localparam logic [2:0] ST_B_ORIENT = 3'd3;
  localparam logic [2:0] ST_B_CHK    = 3'd4;
  localparam logic [2:0] ST_CHECK    = 3'd5;
  localparam logic [2:0] ST_HOLD     = 3'd6;

  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_CHKSUM  = 2'b10;
  localparam logic [1:0] ERR_RANGE   = 2'b11;

  typedef struct packed {
    logic [4:0] piece;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] orient;
  } move_t;

  logic [2:0]    state;
  logic [TW-1:0] to_cnt;
  logic [7:0]    acc;
  logic [7:0]    piece_b;
  logic [7:0]    pos_b;
  logic [7:0]    orient_b;
  logic [7:0]    chk_b;
  move_t         cmd_q;

  logic in_pkt;
  logic byte_take;
  logic to_hit;
  logic pop_req;
  logic chk_bad;
  logic rng_bad;

  // The strobe is registered: a request made in one cycle drives rd_rx_pin
  // low in the next cycle. The byte is taken at the end of that low cycle,
  // while the FIFO still shows it on r_data. A request requires rd_rx_pin=1,
  // so there is always an idle cycle between pops for the FIFO flags to settle.
  assign in_pkt    = (state == ST_B_PIECE) || (state == ST_B_POS) ||
                     (state == ST_B_ORIENT) || (state == ST_B_CHK);
  assign byte_take = ~rd_rx_pin;
  assign to_hit    = in_pkt && !byte_take && (to_cnt == TO_LAST);
  // No new pop is requested on the timeout cycle, so an abandoned packet
  // does not leave a pop in flight.
  assign pop_req   = ((state == ST_HUNT) || in_pkt) && !rx_empty && rd_rx_pin && !to_hit;

  assign chk_bad = (acc != chk_b);
  assign rng_bad = (piece_b > PIECE_LIM) || (pos_b[7:4] > BOARD_LIM) ||
                   (pos_b[3:0] > BOARD_LIM) || (orient_b[7:3] != 5'd0);

  assign busy       = (state != ST_HUNT);
  assign cmd_piece  = cmd_q.piece;
  assign cmd_x      = cmd_q.x;
  assign cmd_y      = cmd_q.y;
  assign cmd_orient = cmd_q.orient;

  always_ff @(posedge clk or negedge reset_pin) begin
    if (!reset_pin) begin
      state     <= ST_HUNT;
      rd_rx_pin <= 1'b1;
      to_cnt    <= '0;
      acc       <= '0;
      piece_b   <= '0;
      pos_b     <= '0;
      orient_b  <= '0;
      chk_b     <= '0;
      cmd_q     <= '0;
      cmd_valid <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      rd_rx_pin <= ~pop_req;
      err_pulse <= 1'b0;

      case (state)
        ST_HUNT: begin
          // Bytes other than SYNC are dropped here without raising an error.
          if (byte_take && (r_data == SYNC_BYTE)) begin
            acc    <= '0;
            to_cnt <= '0;
            state  <= ST_B_PIECE;
          end
        end

        ST_B_PIECE, ST_B_POS, ST_B_ORIENT, ST_B_CHK: begin
          if (byte_take) begin
            to_cnt <= '0;
            case (state)
              ST_B_PIECE: begin
                piece_b <= r_data;
                acc     <= acc ^ r_data;
                state   <= ST_B_POS;
              end
              ST_B_POS: begin
                pos_b <= r_data;
                acc   <= acc ^ r_data;
                state <= ST_B_ORIENT;
              end
              ST_B_ORIENT: begin
                orient_b <= r_data;
                acc      <= acc ^ r_data;
                state    <= ST_B_CHK;
              end
              default: begin
                // CHK is stored separately and is never folded into acc.
                chk_b <= r_data;
                state <= ST_CHECK;
              end
            endcase
          end else if (to_hit) begin
            to_cnt    <= '0;
            err_pulse <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= ST_HUNT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        ST_CHECK: begin
          // A checksum failure is reported in preference to a range failure.
          if (chk_bad) begin
            err_pulse <= 1'b1;
            err_code  <= ERR_CHKSUM;
            state     <= ST_HUNT;
          end else if (rng_bad) begin
            err_pulse <= 1'b1;
            err_code  <= ERR_RANGE;
            state     <= ST_HUNT;
          end else begin
            cmd_q.piece  <= piece_b[4:0];
            cmd_q.x      <= pos_b[7:4];
            cmd_q.y      <= pos_b[3:0];
            cmd_q.orient <= orient_b[2:0];
            cmd_valid    <= 1'b1;
            state        <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= ST_HUNT;
          end
        end

        default: state <= ST_HUNT;
      endcase
    end
  end

`ifdef CMD_SEQ_STATS_EN
  always_ff @(posedge clk or negedge reset_pin) begin
    if (!reset_pin) begin
      cmd_count <= '0;
      err_count <= '0;
    end else begin
      if (cmd_valid && cmd_ready)
        cmd_count <= cmd_count + 16'd1;
      if (err_pulse && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
module tb_uart_cmd_sequencer;
  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       reset_pin = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       cmd_ready = 1'b0;
  logic       rd_rx_pin;
  logic       cmd_valid;
  logic [4:0] cmd_piece;
  logic [3:0] cmd_x;
  logic [3:0] cmd_y;
  logic [2:0] cmd_orient;
  logic       err_pulse;
  logic [1:0] err_code;
  logic       busy;

  always #5 clk = ~clk;

  uart_cmd_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_pin(reset_pin), .rx_empty(rx_empty), .r_data(r_data),
    .rd_rx_pin(rd_rx_pin), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_piece(cmd_piece), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_orient(cmd_orient),
    .err_pulse(err_pulse), .err_code(err_code), .busy(busy)
  );

  // FIFO model: head and empty flag are registered, and a pop takes
  // effect at the edge that closes the rd_rx_pin=0 cycle.
  logic [7:0] q[$];
  int bad_pop = 0;
  always @(posedge clk) begin
    if (!rd_rx_pin) begin
      if (q.size() == 0) bad_pop++;
      else void'(q.pop_front());
    end
    rx_empty <= (q.size() == 0);
    r_data   <= (q.size() != 0) ? q[0] : 8'h00;
  end

  // Event monitor
  int cyc = 0, pops = 0, last_pop_cyc = 0, rise_cyc = 0;
  int acc_cnt = 0, err_hi = 0, vld_hi = 0;
  logic prev_v = 1'b0;
  logic [15:0] last_cmd = '0;
  always @(negedge clk) begin
    cyc++;
    if (!rd_rx_pin) begin pops++; last_pop_cyc = cyc; end
    if (cmd_valid && !prev_v) rise_cyc = cyc;
    prev_v = cmd_valid;
    if (cmd_valid) vld_hi++;
    if (cmd_valid && cmd_ready) begin
      acc_cnt++;
      last_cmd = {cmd_piece, cmd_x, cmd_y, cmd_orient};
    end
    if (err_pulse) err_hi++;
  end

  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push5(input logic [7:0] b0, b1, b2, b3, b4);
    q.push_back(b0); q.push_back(b1); q.push_back(b2); q.push_back(b3); q.push_back(b4);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  int p0;

  initial begin
    // reset
    #2 reset_pin = 1'b0;
    #1;
    check("rst_rd", rd_rx_pin, 1);
    check("rst_valid", cmd_valid, 0);
    check("rst_err", {err_pulse, err_code}, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd", {cmd_piece, cmd_x, cmd_y, cmd_orient}, 0);
    #20;
    @(negedge clk) reset_pin = 1'b1;

    // basic packet
    cmd_ready = 1'b1;
    push5(8'hA5, 8'h05, 8'h37, 8'h02, 8'h30);
    wait_n(40);
    check("p1_acc", acc_cnt, 1);
    check("p1_cmd", last_cmd, {5'd5, 4'd3, 4'd7, 3'd2});
    check("p1_vld_width", vld_hi, 1);
    check("p1_noerr", err_hi, 0);
    check("p1_busy", busy, 0);
    check("p1_latency", rise_cyc - last_pop_cyc, 2);
    check("p1_pops", pops, 5);

    // junk before sync
    q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h12);
    push5(8'hA5, 8'h05, 8'h37, 8'h02, 8'h30);
    wait_n(40);
    check("junk_acc", acc_cnt, 2);
    check("junk_cmd", last_cmd, {5'd5, 4'd3, 4'd7, 3'd2});
    check("junk_noerr", err_hi, 0);
    check("junk_pops", pops, 13);
    check("junk_fifo", q.size(), 0);

    // bad checksum
    push5(8'hA5, 8'h05, 8'h37, 8'h02, 8'h31);
    wait_n(40);
    check("chk_pulse", err_hi, 1);
    check("chk_code", err_code, 2'b10);
    check("chk_novalid", vld_hi, 2);
    check("chk_busy", busy, 0);

    push5(8'hA5, 8'h01, 8'h23, 8'h04, 8'h26);
    wait_n(40);
    check("after_chk_acc", acc_cnt, 3);
    check("after_chk_cmd", last_cmd, {5'd1, 4'd2, 4'd3, 3'd4});

    // range errors and priority
    push5(8'hA5, 8'h15, 8'h37, 8'h02, 8'h20);
    wait_n(40);
    check("rng_piece_pulse", err_hi, 2);
    check("rng_piece_code", err_code, 2'b11);
    push5(8'hA5, 8'h15, 8'h37, 8'h02, 8'h21);
    wait_n(40);
    check("prio_pulse", err_hi, 3);
    check("prio_code", err_code, 2'b10);
    push5(8'hA5, 8'h01, 8'hE2, 8'h00, 8'hE3);
    wait_n(40);
    check("rng_x_pulse", err_hi, 4);
    check("rng_x_code", err_code, 2'b11);
    push5(8'hA5, 8'h00, 8'h00, 8'h08, 8'h08);
    wait_n(40);
    check("rng_or_pulse", err_hi, 5);
    check("rng_or_code", err_code, 2'b11);
    check("rng_acc", acc_cnt, 3);

    // upper boundary values accepted
    push5(8'hA5, 8'h14, 8'hDD, 8'h07, 8'hCE);
    wait_n(40);
    check("bound_acc", acc_cnt, 4);
    check("bound_cmd", last_cmd, {5'd20, 4'd13, 4'd13, 3'd7});

    // SYNC value inside a packet is data
    push5(8'hA5, 8'h01, 8'hA5, 8'h00, 8'hA4);
    wait_n(40);
    check("insync_acc", acc_cnt, 5);
    check("insync_cmd", last_cmd, {5'd1, 4'd10, 4'd5, 3'd0});
    check("insync_noerr", err_hi, 5);

    // inter-byte timeout
    q.push_back(8'hA5); q.push_back(8'h05);
    wait_n(30);
    check("to_early", err_hi, 5);
    check("to_busy", busy, 1);
    wait_n(50);
    check("to_pulse", err_hi, 6);
    check("to_code", err_code, 2'b01);
    check("to_hunt", busy, 0);
    push5(8'hA5, 8'h05, 8'h37, 8'h02, 8'h30);
    wait_n(40);
    check("to_next_acc", acc_cnt, 6);
    check("to_next_cmd", last_cmd, {5'd5, 4'd3, 4'd7, 3'd2});

    // backpressure: hold first command, second stays in FIFO
    cmd_ready = 1'b0;
    p0 = pops;
    push5(8'hA5, 8'h05, 8'h37, 8'h02, 8'h30);
    push5(8'hA5, 8'h14, 8'hDD, 8'h07, 8'hCE);
    wait_n(100);
    check("hold_fifo", q.size(), 5);
    check("hold_valid", cmd_valid, 1);
    check("hold_cmd", {cmd_piece, cmd_x, cmd_y, cmd_orient}, {5'd5, 4'd3, 4'd7, 3'd2});
    check("hold_pops", pops - p0, 5);
    check("hold_rd", rd_rx_pin, 1);
    cmd_ready = 1'b1;
    wait_n(40);
    check("hold_rel_acc", acc_cnt, 8);
    check("hold_rel_cmd", last_cmd, {5'd20, 4'd13, 4'd13, 3'd7});
    check("hold_rel_fifo", q.size(), 0);
    check("hold_rel_valid", cmd_valid, 0);

    // reset while holding a command
    cmd_ready = 1'b0;
    push5(8'hA5, 8'h01, 8'h23, 8'h04, 8'h26);
    wait_n(40);
    check("hrst_pre_valid", cmd_valid, 1);
    check("hrst_pre_busy", busy, 1);
    reset_pin = 1'b0;
    #1;
    check("hrst_valid", cmd_valid, 0);
    check("hrst_busy", busy, 0);
    check("hrst_cmd", {cmd_piece, cmd_x, cmd_y, cmd_orient}, 0);
    check("hrst_err", {err_pulse, err_code}, 0);
    check("hrst_rd", rd_rx_pin, 1);
    wait_n(2);
    reset_pin = 1'b1;
    wait_n(10);
    check("hrst_after_valid", cmd_valid, 0);
    check("no_empty_pop", bad_pop, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
Drains the UART receive FIFO and assembles fixed 5-byte move packets from the host into one validated Blokus move command. Sits between the receive FIFO (head data shown on r_data while not empty, popped by an active-low one-cycle read strobe) and the game-logic move consumer. Handles sync hunting, inter-byte timeout, checksum and range checks. Holds the FIFO via backpressure while a command waits to be consumed.

Parameters:
SYNC_BYTE, 8'hA5, packet start marker
TIMEOUT_CYCLES, 200000, max clk cycles between bytes inside a packet (counter width = clog2)
BOARD_MAX, 13, highest legal x/y coordinate (14x14 board)
PIECE_MAX, 20, highest legal piece id (21 pieces)

Ports:
clk  in  1  system clock
reset_pin  in  1  asynchronous active-low reset
rx_empty  in  1  FIFO empty flag
r_data  in  8  FIFO head byte, valid while rx_empty=0
rd_rx_pin  out  1  active-low FIFO pop strobe, one cycle wide
cmd_valid  out  1  command available
cmd_ready  in  1  consumer accepts command
cmd_piece  out  5  piece id
cmd_x  out  4  column
cmd_y  out  4  row
cmd_orient  out  3  orientation/flip code
err_pulse  out  1  one-cycle error strobe
err_code  out  2  01 timeout, 10 checksum, 11 range; held until next error
busy  out  1  high in any state except HUNT

Behaviour:
- Reset (async, reset_pin=0): state HUNT, rd_rx_pin=1, cmd_valid=0, cmd_* =0, err_pulse=0, err_code=00, busy=0, timeout counter=0, checksum acc=0.
- Packet: SYNC, PIECE, POS (x=[7:4], y=[3:0]), ORIENT (bits[2:0], [7:3] must be 0), CHK = PIECE^POS^ORIENT.
- Pop rule: byte sampled from r_data in the same cycle rd_rx_pin=0 is driven registered-low; the strobe is asserted only when rx_empty=0; at least one idle cycle (rd_rx_pin=1) between pops so FIFO pointers/flags settle. Never pop when rx_empty=1.
- States: HUNT -> B_PIECE -> B_POS -> B_ORIENT -> B_CHK -> CHECK -> HOLD -> HUNT.
- HUNT: pop bytes; byte==SYNC_BYTE -> B_PIECE, else discard silently (no error).
- B_* states: each popped byte stored, XORed into acc (acc cleared on SYNC), timeout counter cleared; next state advances.
- Timeout: counter increments each cycle in B_* while no byte popped; reaching TIMEOUT_CYCLES-1 -> err_pulse=1, err_code=01, state HUNT.
- CHECK (one cycle, no pop): acc!=CHK -> err 10; else piece>PIECE_MAX or x>BOARD_MAX or y>BOARD_MAX or ORIENT[7:3]!=0 -> err 11; checksum has priority. Error -> HUNT. Pass -> load cmd_* registers, cmd_valid=1, HOLD.
- HOLD: cmd_* stable, no pops (FIFO absorbs incoming bytes; overflow is FIFO's concern). cmd_valid&cmd_ready -> cmd_valid=0 next cycle, HUNT. Latency last-CHK-pop to cmd_valid: 2 cycles.
- cmd_ready ignored when cmd_valid=0. A SYNC byte inside a packet is data, not a restart.
- err_pulse exactly one cycle per error; simultaneous conditions impossible (single state).
- Reset mid-packet or in HOLD: all cleared immediately, pending command dropped, partial bytes not re-read.

Optional Feature:
CMD_SEQ_STATS_EN: when defined, adds outputs cmd_count[15:0] (accepted commands, increments on cmd_valid&cmd_ready) and err_count[7:0] (increments on err_pulse, saturates at 8'hFF; cmd_count wraps). Both reset to 0. Undefined: ports and counters absent, behaviour otherwise identical.

Test Plan:
- Bytes A5 05 37 02 30, cmd_ready=1 -> cmd_valid one cycle, piece=5, x=3, y=7, orient=2, no error, busy back to 0.
- Junk 00 FF 12 then A5 05 37 02 30 -> junk popped, no err_pulse, same command produced.
- A5 05 37 02 31 -> err_pulse one cycle, err_code=10, cmd_valid stays 0, next valid packet accepted.
- A5 15 37 02 20 (piece 21) -> err_code=11; A5 01 E2 00 E3 (x=14) -> err_code=11.
- A5 05 then no bytes for TIMEOUT_CYCLES (bench sets 50) -> err_code=01 after 50 cycles, state HUNT; following full packet accepted.
- Two packets back to back, cmd_ready=0 for 100 cycles -> first command held stable, rd_rx_pin stays 1, second packet remains in FIFO; raise cmd_ready -> second command follows. Reset asserted in HOLD -> all outputs at reset values immediately.
